axi_gp_reg_slave: RTL and testbench
===================================

AXI_GP_REG_SLAVE -- requirements
Module: axi_gp_reg_slave

Interface
REQ-001 Parameter NUM_REGS, default 16, gives the total 32-bit register count, power of two, 4..256.
REQ-002 Parameter NUM_CTRL, default 8, gives the number of read/write control registers at indices 0..NUM_CTRL-1; indices NUM_CTRL..NUM_REGS-1 are read-only status.
REQ-003 Parameter ID_WIDTH, default 12, gives the AXI ID width.
REQ-004 The port list SHALL be:
- ap_clk  in  1  single clock; all logic is on its rising edge.
- ap_rst  in  1  synchronous active-high reset.
- s_axi  axi4 slave  -  GP-side AXI3-style port: aw*/w*/b*/ar*/r* with 32-bit addr and data, 4-bit len, ID_WIDTH ids and wid.
- ctrl_out  out  NUM_CTRL*32  current control register contents, register i at bits [32i+31:32i].
- ctrl_wr_pulse  out  NUM_CTRL  one-cycle strobe per control register written.
- status_in  in  (NUM_REGS-NUM_CTRL)*32  live status words, sampled when read.

Function
REQ-005 The register index SHALL be addr[2+:log2(NUM_REGS)]; upper address bits SHALL be ignored.
REQ-006 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP, and the read FSM SHALL have states R_IDLE and R_DATA; the two FSMs are independent.
REQ-007 In W_IDLE, awready SHALL be 1; on the awvalid&awready cycle the block SHALL latch awid, awaddr, awlen, awburst and awsize, clear the beat counter and go to W_DATA.
REQ-008 In W_DATA, wready SHALL be 1; each wvalid&wready beat SHALL update the selected control register per byte lane where wstrb[b]=1 and pulse its ctrl_wr_pulse bit in the next cycle.
REQ-009 For INCR bursts the index SHALL increment by 1 per beat, wrapping modulo NUM_REGS; for FIXED bursts it SHALL stay constant.
REQ-010 The beat with wlast=1 SHALL end W_DATA and move the FSM to W_RESP; bvalid=1 in W_RESP, bid=latched awid, and the FSM returns to W_IDLE on bready.
REQ-011 bresp SHALL be SLVERR (2'b10) when awsize≠2, awburst=WRAP, any beat hits a status index, or wlast arrives at beat count≠awlen; otherwise it is OKAY.
REQ-012 Beats that are erroneous (wrong size, WRAP burst, or status index) SHALL NOT modify any register.
REQ-013 If the beat count reaches awlen without wlast, the block SHALL keep accepting beats without writing them until wlast and respond SLVERR.
REQ-014 In R_IDLE, arready SHALL be 1; an AR handshake SHALL latch arid, araddr, arlen, arburst and arsize and go to R_DATA, with rvalid first asserted the next cycle.
REQ-015 rdata SHALL be registered: a control index returns the register value and a status index returns status_in sampled on the cycle the beat is loaded.
REQ-016 Each read beat SHALL hold rdata, rid, rresp and rlast stable until rready; the index advances per REQ-009 and the next beat is presented in the following cycle.
REQ-017 rlast SHALL be 1 exactly on beat arlen.
REQ-018 A read with arsize≠2 or arburst=WRAP SHALL return rdata=0 and rresp=SLVERR on all arlen+1 beats; the FSM returns to R_IDLE after the rlast handshake.
REQ-019 When a write and a read of the same register handshake in the same cycle, the read SHALL return the pre-write value.
REQ-020 Write throughput SHALL be one beat per cycle; read throughput SHALL be one beat per two cycles maximum (load, present).

Reset
REQ-021 On ap_rst=1 at a clock edge: both FSMs go to idle, all control registers=0, ctrl_wr_pulse=0, bvalid=rvalid=0, awready=arready=wready=0.
REQ-022 awready and arready SHALL assert on the first cycle after ap_rst deasserts.
REQ-023 A burst in progress at reset SHALL be abandoned with no response; register writes already completed SHALL be cleared.

Verification
REQ-024 Single write: AW addr 0x8 len 0 size 2 INCR, W 0xA5A5_1234 strb 4'hF -> ctrl_out[95:64]=0xA5A51234, ctrl_wr_pulse=3'b100 for one cycle, B OKAY with matching bid.
REQ-025 Strobed write: reg1=0xFFFF_FFFF, then write 0x0000_0000 with strb 4'b0101 -> reg1=0xFF00_FF00.
REQ-026 INCR read burst: addr 0x18 len 3 with status_in words 0x11,0x22 at indices 8,9 (NUM_CTRL=8) -> rdata reg6, reg7, 0x11, 0x22 in order, rlast only on the 4th beat, all rresp OKAY.
REQ-027 Errors: write to index 10 -> SLVERR and no change; WRAP read len 1 -> two beats of rdata=0 SLVERR; write len 2 with wlast on beat 1 -> SLVERR.
REQ-028 Backpressure and reset: hold rready=0 for 5 cycles mid-burst -> data held stable; assert ap_rst mid-write-burst -> all outputs zero next cycle and awready=1 one cycle after release.

Source files
------------

// File: rtl/axi_gp_reg_slave.sv
// AXI3-style GP register slave: NUM_CTRL read/write control words followed by
// read-only status words. Independent write (AW/W/B) and read (AR/R) engines.
module axi_gp_reg_slave #(
    parameter int NUM_REGS = 16,
    parameter int NUM_CTRL = 8,
    parameter int ID_WIDTH = 12
) (
    input  logic                              ap_clk,
    input  logic                              ap_rst,
    // write address channel
    input  logic [ID_WIDTH-1:0]               s_axi_awid,
    input  logic [31:0]                       s_axi_awaddr,
    input  logic [3:0]                        s_axi_awlen,
    input  logic [2:0]                        s_axi_awsize,
    input  logic [1:0]                        s_axi_awburst,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    // write data channel
    input  logic [ID_WIDTH-1:0]               s_axi_wid,
    input  logic [31:0]                       s_axi_wdata,
    input  logic [3:0]                        s_axi_wstrb,
    input  logic                              s_axi_wlast,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    // write response channel
    output logic [ID_WIDTH-1:0]               s_axi_bid,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    // read address channel
    input  logic [ID_WIDTH-1:0]               s_axi_arid,
    input  logic [31:0]                       s_axi_araddr,
    input  logic [3:0]                        s_axi_arlen,
    input  logic [2:0]                        s_axi_arsize,
    input  logic [1:0]                        s_axi_arburst,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    // read data channel
    output logic [ID_WIDTH-1:0]               s_axi_rid,
    output logic [31:0]                       s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rlast,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    // register file side
    output logic [NUM_CTRL*32-1:0]            ctrl_out,
    output logic [NUM_CTRL-1:0]               ctrl_wr_pulse,
    input  logic [(NUM_REGS-NUM_CTRL)*32-1:0] status_in
);

    localparam int         IDX_W      = $clog2(NUM_REGS);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // ------------------------------------------------------------------
    // Register storage and the unified read view
    // ------------------------------------------------------------------
    logic [31:0]         ctrl_reg [NUM_CTRL];
    logic [NUM_CTRL-1:0] pulse_reg;
    logic [31:0]         reg_word [NUM_REGS];

    for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl_out
        assign ctrl_out[gi*32 +: 32] = ctrl_reg[gi];
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
        if (gi < NUM_CTRL) begin : g_is_ctrl
            assign reg_word[gi] = ctrl_reg[gi];
        end else begin : g_is_status
            assign reg_word[gi] = status_in[(gi-NUM_CTRL)*32 +: 32];
        end
    end

    assign ctrl_wr_pulse = pulse_reg;

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    w_state_t            w_state_reg, w_state_next;
    logic                awready_reg, awready_next;
    logic                wready_reg, wready_next;
    logic                bvalid_reg, bvalid_next;
    logic [1:0]          bresp_reg;
    logic [ID_WIDTH-1:0] aw_id_reg;
    logic [IDX_W-1:0]    w_idx_reg;
    logic [3:0]          aw_len_reg;
    logic [1:0]          aw_burst_reg;
    logic [2:0]          aw_size_reg;
    logic [3:0]          w_cnt_reg;
    logic                w_over_reg;
    logic                w_err_reg;

    logic aw_hs, w_hs, b_hs;
    logic w_beat_err, w_beat_ok, w_len_err;

    assign aw_hs = s_axi_awvalid & awready_reg;
    assign w_hs  = s_axi_wvalid & wready_reg;
    assign b_hs  = bvalid_reg & s_axi_bready;

    // A beat is refused if the burst shape is illegal or it lands on status.
    assign w_beat_err = (aw_size_reg != 3'd2) || (aw_burst_reg == BURST_WRAP) ||
                        (w_idx_reg >= IDX_W'(NUM_CTRL));
    // Beats past awlen are swallowed until wlast shows up.
    assign w_beat_ok  = w_hs && !w_beat_err && !w_over_reg;
    assign w_len_err  = w_over_reg || (w_cnt_reg != aw_len_reg);

    // Write FSM state and handshake flags
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            awready_reg <= awready_next;
            wready_reg  <= wready_next;
            bvalid_reg  <= bvalid_next;
        end
    end

    // Write FSM next state; ready/valid flags follow the next state
    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (aw_hs) w_state_next = W_DATA;
            W_DATA:  if (w_hs && s_axi_wlast) w_state_next = W_RESP;
            W_RESP:  if (b_hs) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
        awready_next = (w_state_next == W_IDLE);
        wready_next  = (w_state_next == W_DATA);
        bvalid_next  = (w_state_next == W_RESP);
    end

    // Write burst bookkeeping: latched AW fields, beat count, error summary
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            aw_id_reg    <= '0;
            w_idx_reg    <= '0;
            aw_len_reg   <= '0;
            aw_burst_reg <= '0;
            aw_size_reg  <= '0;
            w_cnt_reg    <= '0;
            w_over_reg   <= 1'b0;
            w_err_reg    <= 1'b0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_id_reg    <= s_axi_awid;
                w_idx_reg    <= s_axi_awaddr[2 +: IDX_W];
                aw_len_reg   <= s_axi_awlen;
                aw_burst_reg <= s_axi_awburst;
                aw_size_reg  <= s_axi_awsize;
                w_cnt_reg    <= '0;
                w_over_reg   <= 1'b0;
                w_err_reg    <= 1'b0;
            end
            if (w_hs) begin
                if (w_beat_err) begin
                    w_err_reg <= 1'b1;
                end
                if (aw_burst_reg != BURST_FIXED) begin
                    w_idx_reg <= w_idx_reg + IDX_W'(1);
                end
                if (w_cnt_reg == aw_len_reg) begin
                    w_over_reg <= 1'b1;
                end else begin
                    w_cnt_reg <= w_cnt_reg + 4'd1;
                end
                if (s_axi_wlast) begin
                    bresp_reg <= (w_err_reg || w_beat_err || w_len_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Control register byte-lane updates and their one-cycle write strobes
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                ctrl_reg[i] <= '0;
            end
            pulse_reg <= '0;
        end else begin
            pulse_reg <= '0;
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (w_beat_ok && (w_idx_reg == IDX_W'(i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_axi_wstrb[b]) begin
                            ctrl_reg[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                        end
                    end
                    pulse_reg[i] <= 1'b1;
                end
            end
        end
    end

    assign s_axi_awready = awready_reg;
    assign s_axi_wready  = wready_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bresp   = bresp_reg;
    assign s_axi_bid     = aw_id_reg;

    // ------------------------------------------------------------------
    // Read engine: each beat is loaded in one cycle and presented in the next
    // ------------------------------------------------------------------
    r_state_t            r_state_reg, r_state_next;
    logic                arready_reg, arready_next;
    logic                rvalid_reg, rvalid_next;
    logic [31:0]         rdata_reg;
    logic [1:0]          rresp_reg;
    logic                rlast_reg;
    logic [ID_WIDTH-1:0] rid_reg;
    logic [IDX_W-1:0]    r_idx_reg;
    logic [3:0]          ar_len_reg;
    logic [1:0]          ar_burst_reg;
    logic [2:0]          ar_size_reg;
    logic [3:0]          r_cnt_reg;

    logic             ar_hs, r_hs, r_load;
    logic [IDX_W-1:0] load_idx;
    logic [3:0]       load_cnt;
    logic [3:0]       load_len;
    logic             load_err;
    logic             load_incr;

    assign ar_hs = s_axi_arvalid & arready_reg;
    assign r_hs  = rvalid_reg & s_axi_rready;

    // Read FSM state and handshake flags
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            arready_reg <= arready_next;
            rvalid_reg  <= rvalid_next;
        end
    end

    // Read FSM next state; rvalid drops for the load cycle after each handshake
    always_comb begin
        r_state_next = r_state_reg;
        rvalid_next  = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_next = R_DATA;
                    rvalid_next  = 1'b1;
                end
            end
            R_DATA: begin
                if (r_hs && rlast_reg) begin
                    r_state_next = R_IDLE;
                end
                rvalid_next = rvalid_reg ? !s_axi_rready : 1'b1;
            end
            default: r_state_next = R_IDLE;
        endcase
        arready_next = (r_state_next == R_IDLE);
    end

    // Select the beat to load: straight from AR on the handshake, else from the burst state
    always_comb begin
        r_load    = 1'b0;
        load_idx  = r_idx_reg;
        load_cnt  = r_cnt_reg;
        load_len  = ar_len_reg;
        load_err  = (ar_size_reg != 3'd2) || (ar_burst_reg == BURST_WRAP);
        load_incr = (ar_burst_reg != BURST_FIXED);
        if (ar_hs) begin
            r_load    = 1'b1;
            load_idx  = s_axi_araddr[2 +: IDX_W];
            load_cnt  = '0;
            load_len  = s_axi_arlen;
            load_err  = (s_axi_arsize != 3'd2) || (s_axi_arburst == BURST_WRAP);
            load_incr = (s_axi_arburst != BURST_FIXED);
        end else if ((r_state_reg == R_DATA) && !rvalid_reg) begin
            r_load = 1'b1;
        end
    end

    // Read beat registers; status words are captured on the load cycle
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
            rlast_reg    <= 1'b0;
            rid_reg      <= '0;
            r_idx_reg    <= '0;
            ar_len_reg   <= '0;
            ar_burst_reg <= '0;
            ar_size_reg  <= '0;
            r_cnt_reg    <= '0;
        end else begin
            if (ar_hs) begin
                rid_reg      <= s_axi_arid;
                ar_len_reg   <= s_axi_arlen;
                ar_burst_reg <= s_axi_arburst;
                ar_size_reg  <= s_axi_arsize;
            end
            if (r_load) begin
                rdata_reg <= load_err ? 32'h0 : reg_word[load_idx];
                rresp_reg <= load_err ? RESP_SLVERR : RESP_OKAY;
                rlast_reg <= (load_cnt == load_len);
                r_cnt_reg <= load_cnt + 4'd1;
                r_idx_reg <= load_incr ? (load_idx + IDX_W'(1)) : load_idx;
            end
        end
    end

    assign s_axi_arready = arready_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = rresp_reg;
    assign s_axi_rlast   = rlast_reg;
    assign s_axi_rid     = rid_reg;

    // Address bits outside the register index and the AXI3 write ID carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr[31:IDX_W+2], s_axi_awaddr[1:0],
                           s_axi_araddr[31:IDX_W+2], s_axi_araddr[1:0], s_axi_wid};

endmodule

// File: tb/tb_axi_gp_reg_slave.sv
// Directed bench for axi_gp_reg_slave: a table of single-beat transactions
// plus hand sequences for bursts, errors, backpressure and mid-burst reset.
module tb_axi_gp_reg_slave;

    logic         clk = 1'b0;
    logic         ap_rst;
    logic [11:0]  awid, wid, bid, arid, rid;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [3:0]   awlen, wstrb, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, bresp, arburst, rresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic [255:0] ctrl_out;
    logic [7:0]   ctrl_wr_pulse;
    logic [255:0] status_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [11:0] rd_id   [16];
    int          rd_n;

    always #5 clk = ~clk;

    axi_gp_reg_slave #(.NUM_REGS(16), .NUM_CTRL(8), .ID_WIDTH(12)) dut (
        .ap_clk(clk), .ap_rst(ap_rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ctrl_out(ctrl_out), .ctrl_wr_pulse(ctrl_wr_pulse), .status_in(status_in)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write transaction; data increments by one per beat, wlast on the final beat.
    task automatic do_write(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [31:0] data,
                            input logic [3:0] strb, input int nbeats,
                            output logic [1:0] resp, output logic [11:0] rbid, output logic [7:0] pulse);
        int  t;
        logic rdy;
        resp = 2'b11; rbid = '0; pulse = '0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        do begin rdy = awready; tick(); t++; end while (!rdy && t < 50);
        awvalid = 1'b0;
        if (!rdy) begin check("aw_timeout", 32'd0, 32'd1); return; end
        for (int b = 0; b < nbeats; b++) begin
            wid = id; wdata = data + 32'(b); wstrb = strb; wlast = (b == nbeats - 1); wvalid = 1'b1;
            t = 0;
            do begin rdy = wready; tick(); t++; end while (!rdy && t < 50);
            if (!rdy) begin wvalid = 1'b0; check("w_timeout", 32'd0, 32'd1); return; end
            pulse = ctrl_wr_pulse;
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (!bvalid && t < 50) begin tick(); t++; end
        if (!bvalid) begin check("b_timeout", 32'd0, 32'd1); return; end
        resp = bresp; rbid = bid;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        $display("write id=%03h addr=%08h len=%0d beats=%0d bresp=%0d", id, addr, len, nbeats, resp);
    endtask

    // Full read transaction; optionally stalls rready for hold_cyc cycles on beat hold_beat.
    task automatic do_read(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int hold_beat, input int hold_cyc, input logic [31:0] hold_exp);
        int  t;
        logic rdy;
        rd_n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        do begin rdy = arready; tick(); t++; end while (!rdy && t < 50);
        arvalid = 1'b0;
        if (!rdy) begin check("ar_timeout", 32'd0, 32'd1); return; end
        while (rd_n < 16) begin
            t = 0;
            while (!rvalid && t < 50) begin tick(); t++; end
            if (!rvalid) begin check("r_timeout", 32'd0, 32'd1); return; end
            if (rd_n == hold_beat) begin
                for (int k = 0; k < hold_cyc; k++) begin
                    tick();
                    check($sformatf("hold%0d_rvalid", k), 32'(rvalid), 32'd1);
                    check($sformatf("hold%0d_rdata", k), rdata, hold_exp);
                end
            end
            rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast; rd_id[rd_n] = rid;
            rready = 1'b1;
            tick();
            rready = 1'b0;
            rd_n++;
            if (rd_last[rd_n-1]) break;
        end
        $display("read  id=%03h addr=%08h len=%0d beats=%0d rresp0=%0d rdata0=%08h",
                 id, addr, len, rd_n, rd_resp[0], rd_data[0]);
    endtask

    typedef struct {
        logic        is_read;
        logic [11:0] id;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    initial begin
        logic [1:0]  resp;
        logic [11:0] rbid;
        logic [7:0]  pulse;
        logic [31:0] exp_burst [4];

        // single-beat INCR transactions; state carries from one row to the next
        vecs[0]  = '{1'b1, 12'h010, 32'h0000_0000, 3'd2, 32'h0,          4'h0,    2'b00, 32'h0000_0000};
        vecs[1]  = '{1'b0, 12'h011, 32'h0000_0004, 3'd2, 32'hFFFF_FFFF,  4'hF,    2'b00, 32'h0};
        vecs[2]  = '{1'b0, 12'h012, 32'h0000_0004, 3'd2, 32'h0000_0000,  4'b0101, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 12'h013, 32'h0000_0004, 3'd2, 32'h0,          4'h0,    2'b00, 32'hFF00_FF00};
        vecs[4]  = '{1'b0, 12'h014, 32'h0000_0028, 3'd2, 32'h1234_5678,  4'hF,    2'b10, 32'h0};
        vecs[5]  = '{1'b1, 12'h015, 32'h0000_0028, 3'd2, 32'h0,          4'h0,    2'b00, 32'h0000_0033};
        vecs[6]  = '{1'b0, 12'h016, 32'h0000_000C, 3'd1, 32'hDEAD_BEEF,  4'hF,    2'b10, 32'h0};
        vecs[7]  = '{1'b1, 12'h017, 32'h0000_000C, 3'd2, 32'h0,          4'h0,    2'b00, 32'h0000_0000};
        vecs[8]  = '{1'b0, 12'h018, 32'h0000_040C, 3'd2, 32'hCAFE_F00D,  4'hF,    2'b00, 32'h0};
        vecs[9]  = '{1'b1, 12'h019, 32'h0000_000C, 3'd2, 32'h0,          4'h0,    2'b00, 32'hCAFE_F00D};
        vecs[10] = '{1'b0, 12'h01A, 32'h0000_001C, 3'd2, 32'h8765_4321,  4'b1000, 2'b00, 32'h0};
        vecs[11] = '{1'b1, 12'h01B, 32'hFFFF_FF9C, 3'd2, 32'h0,          4'h0,    2'b00, 32'h8700_0000};
        vecs[12] = '{1'b1, 12'h01C, 32'h0000_0000, 3'd1, 32'h0,          4'h0,    2'b10, 32'h0000_0000};
        vecs[13] = '{1'b1, 12'h01D, 32'h0000_003C, 3'd2, 32'h0,          4'h0,    2'b00, 32'h0000_0088};
        vecs[14] = '{1'b0, 12'h01E, 32'h0000_0018, 3'd2, 32'h6666_6666,  4'hF,    2'b00, 32'h0};

        for (int k = 0; k < 8; k++) status_in[k*32 +: 32] = 32'(17 * (k + 1));
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        // reset and the first idle cycle afterwards
        ap_rst = 1'b1;
        repeat (3) tick();
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        ap_rst = 1'b0;
        tick();
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);
        check("post_rst_wready", 32'(wready), 32'd0);
        check("post_rst_bvalid", 32'(bvalid), 32'd0);
        check("post_rst_rvalid", 32'(rvalid), 32'd0);
        check("post_rst_ctrl_zero", 32'(ctrl_out == '0), 32'd1);
        check("post_rst_pulse", 32'(ctrl_wr_pulse), 32'd0);

        // single write to index 2
        do_write(12'h5A3, 32'h8, 4'd0, 3'd2, 2'b01, 32'hA5A5_1234, 4'hF, 1, resp, rbid, pulse);
        check("single_bresp", 32'(resp), 32'd0);
        check("single_bid", 32'(rbid), 32'h5A3);
        check("single_pulse", 32'(pulse), 32'h04);
        check("single_pulse_gone", 32'(ctrl_wr_pulse), 32'd0);
        check("single_reg2", ctrl_out[95:64], 32'hA5A5_1234);

        // table of single-beat transactions
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_read) begin
                do_read(vecs[i].id, vecs[i].addr, 4'd0, vecs[i].size, 2'b01, -1, 0, 32'h0);
                check($sformatf("v%0d_beats", i), 32'(rd_n), 32'd1);
                check($sformatf("v%0d_rdata", i), rd_data[0], vecs[i].exp_rdata);
                check($sformatf("v%0d_rresp", i), 32'(rd_resp[0]), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_rid", i), 32'(rd_id[0]), 32'(vecs[i].id));
                check($sformatf("v%0d_rlast", i), 32'(rd_last[0]), 32'd1);
            end else begin
                do_write(vecs[i].id, vecs[i].addr, 4'd0, vecs[i].size, 2'b01, vecs[i].wdata,
                         vecs[i].strb, 1, resp, rbid, pulse);
                check($sformatf("v%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_bid", i), 32'(rbid), 32'(vecs[i].id));
            end
        end

        // INCR read burst across the control/status boundary, stalled 5 cycles on beat 1
        exp_burst[0] = 32'h6666_6666; exp_burst[1] = 32'h8700_0000;
        exp_burst[2] = 32'h0000_0011; exp_burst[3] = 32'h0000_0022;
        do_read(12'h0AB, 32'h18, 4'd3, 3'd2, 2'b01, 1, 5, 32'h8700_0000);
        check("burst_beats", 32'(rd_n), 32'd4);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("burst%0d_rdata", b), rd_data[b], exp_burst[b]);
            check($sformatf("burst%0d_rlast", b), 32'(rd_last[b]), (b == 3) ? 32'd1 : 32'd0);
            check($sformatf("burst%0d_rresp", b), 32'(rd_resp[b]), 32'd0);
            check($sformatf("burst%0d_rid", b), 32'(rd_id[b]), 32'h0AB);
        end

        // WRAP read: two error beats of zero data
        do_read(12'h0C1, 32'h0, 4'd1, 3'd2, 2'b10, -1, 0, 32'h0);
        check("wrap_beats", 32'(rd_n), 32'd2);
        for (int b = 0; b < 2; b++) begin
            check($sformatf("wrap%0d_rdata", b), rd_data[b], 32'h0);
            check($sformatf("wrap%0d_rresp", b), 32'(rd_resp[b]), 32'd2);
            check($sformatf("wrap%0d_rlast", b), 32'(rd_last[b]), (b == 1) ? 32'd1 : 32'd0);
        end

        // early wlast: len 2, wlast on beat 1
        do_write(12'h0D2, 32'h0, 4'd2, 3'd2, 2'b01, 32'h1234_0000, 4'hF, 2, resp, rbid, pulse);
        check("early_wlast_bresp", 32'(resp), 32'd2);

        // overrun: len 0 but three beats; only the first lands in reg5
        do_write(12'h0E3, 32'h14, 4'd0, 3'd2, 2'b01, 32'h5555_0000, 4'hF, 3, resp, rbid, pulse);
        check("overrun_bresp", 32'(resp), 32'd2);
        check("overrun_reg5", ctrl_out[191:160], 32'h5555_0000);
        check("overrun_reg6", ctrl_out[223:192], 32'h6666_6666);

        // FIXED write burst: both beats hit reg4
        do_write(12'h0F4, 32'h10, 4'd1, 3'd2, 2'b00, 32'h4444_0000, 4'hF, 2, resp, rbid, pulse);
        check("fixed_bresp", 32'(resp), 32'd0);
        check("fixed_reg4", ctrl_out[159:128], 32'h4444_0001);
        check("fixed_reg5", ctrl_out[191:160], 32'h5555_0000);

        // reset in the middle of a write burst
        awid = 12'h111; awaddr = 32'h0; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata = 32'h1111_0000; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        tick();
        wdata = 32'h2222_0000;
        tick();
        check("midrst_reg0_before", ctrl_out[31:0], 32'h1111_0000);
        check("midrst_reg1_before", ctrl_out[63:32], 32'h2222_0000);
        ap_rst = 1'b1;
        tick();
        wvalid = 1'b0;
        check("midrst_ctrl_zero", 32'(ctrl_out == '0), 32'd1);
        check("midrst_pulse", 32'(ctrl_wr_pulse), 32'd0);
        check("midrst_awready", 32'(awready), 32'd0);
        check("midrst_wready", 32'(wready), 32'd0);
        check("midrst_arready", 32'(arready), 32'd0);
        check("midrst_bvalid", 32'(bvalid), 32'd0);
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        ap_rst = 1'b0;
        tick();
        check("midrst_awready_after", 32'(awready), 32'd1);
        check("midrst_bvalid_after", 32'(bvalid), 32'd0);

        // registers written before the reset are gone
        do_read(12'h222, 32'h4, 4'd0, 3'd2, 2'b01, -1, 0, 32'h0);
        check("post_midrst_rdata", rd_data[0], 32'h0);
        check("post_midrst_rresp", 32'(rd_resp[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
